// File: rtl/ps2_host_ctrl_if.sv
// PS/2 host controller bundle: pad lines, command (TX) handshake and
// scan-code (RX) stream. The controller uses the slave modport; the
// surrounding system (or a bench) uses the master modport.
`timescale 1ns/1ps
interface ps2_host_ctrl_if;
  logic       ps2_clk_i;
  logic       ps2_data_i;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_err;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_err;
  logic       rx_overflow;
  logic       busy;

  modport slave (
    input  ps2_clk_i, ps2_data_i, tx_valid, tx_data, rx_ready,
    output ps2_clk_oe, ps2_data_oe, tx_ready, tx_done, tx_err,
           rx_data, rx_valid, rx_err, rx_overflow, busy
  );

  modport master (
    output ps2_clk_i, ps2_data_i, tx_valid, tx_data, rx_ready,
    input  ps2_clk_oe, ps2_data_oe, tx_ready, tx_done, tx_err,
           rx_data, rx_valid, rx_err, rx_overflow, busy
  );
endinterface

// File: rtl/ps2_host_ctrl.sv
// PS/2 host controller: receives device frames into an RX FIFO and sends
// host command bytes with the inhibit / request-to-send / ACK sequence.
`timescale 1ns/1ps
module ps2_host_ctrl #(
  parameter int FIFO_DEPTH      = 8,
  parameter int INHIBIT_CYC     = 5000,
  parameter int BIT_TIMEOUT_CYC = 10000,
  parameter int REQ_TIMEOUT_CYC = 750000
) (
  input logic            clk,
  input logic            rst,
  ps2_host_ctrl_if.slave bus
);

  localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PW      = AW + 1;
  localparam int MAX_A   = (INHIBIT_CYC > BIT_TIMEOUT_CYC) ? INHIBIT_CYC : BIT_TIMEOUT_CYC;
  localparam int MAX_CYC = (MAX_A > REQ_TIMEOUT_CYC) ? MAX_A : REQ_TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYC - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] REQ_LAST = CNT_W'(REQ_TIMEOUT_CYC - 1);
  localparam logic [PW-1:0]    DEPTH_P  = PW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, RX_SHIFT, TX_INHIBIT, TX_REQ, TX_SHIFT, TX_ACK, TX_WAIT_IDLE
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       bit_cnt, bit_n;
  logic [8:0]       shreg, shreg_n;
  logic [8:0]       frame, frame_n;
  logic             clk_oe, clk_oe_n, data_oe, data_oe_n;
  logic             tx_done_r, tx_done_n, tx_err_r, tx_err_n;
  logic             rx_err_r, rx_err_n, rx_ovf_r, rx_ovf_n;
  logic             push, pop, full, empty;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [7:0]       mem [FIFO_DEPTH];
  logic             clk_p0, clk_p1, clk_p2, dat_p0, dat_p1, dat_p2;
  logic             fall, din, lines_high;

  // Odd parity bit for a byte: set when the byte holds an even number of ones.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  assign fall       = clk_p2 & ~clk_p1;
  assign din        = dat_p1;
  assign lines_high = clk_p1 & dat_p1;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = ((wr_ptr - rd_ptr) == DEPTH_P);
  assign pop   = ~empty & bus.rx_ready;

  // Next-state and next-output logic for the link state machine.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    bit_n     = bit_cnt;
    shreg_n   = shreg;
    frame_n   = frame;
    clk_oe_n  = clk_oe;
    data_oe_n = data_oe;
    tx_done_n = 1'b0;
    tx_err_n  = 1'b0;
    rx_err_n  = 1'b0;
    rx_ovf_n  = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE: begin
        cnt_n     = '0;
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        // A command wins over a device start bit seen on the same cycle.
        if (bus.tx_valid) begin
          frame_n  = {odd_parity(bus.tx_data), bus.tx_data};
          clk_oe_n = 1'b1;
          state_n  = TX_INHIBIT;
        end else if (fall && !din) begin
          bit_n   = 4'd1;
          state_n = RX_SHIFT;
        end
      end
      RX_SHIFT: begin
        if (fall) begin
          cnt_n = '0;
          bit_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd10) begin
            state_n = IDLE;
            // shreg holds {parity, data}; a good frame has odd ones and stop = 1.
            if (din && (^shreg)) begin
              if (full && !pop) rx_ovf_n = 1'b1;
              else              push     = 1'b1;
            end else begin
              rx_err_n = 1'b1;
            end
          end else begin
            shreg_n = {din, shreg[8:1]};
          end
        end else if (cnt == BIT_LAST) begin
          rx_err_n = 1'b1;
          state_n  = IDLE;
        end
      end
      TX_INHIBIT: begin
        if (cnt == INH_LAST) begin
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b1;
          cnt_n     = '0;
          state_n   = TX_REQ;
        end
      end
      TX_REQ: begin
        if (fall) begin
          data_oe_n = ~frame[0];
          bit_n     = 4'd1;
          cnt_n     = '0;
          state_n   = TX_SHIFT;
        end else if (cnt == REQ_LAST) begin
          tx_err_n  = 1'b1;
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b0;
          state_n   = IDLE;
        end
      end
      TX_SHIFT: begin
        if (fall) begin
          cnt_n = '0;
          bit_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd9) begin
            data_oe_n = 1'b0;
            state_n   = TX_ACK;
          end else begin
            data_oe_n = ~frame[bit_cnt];
          end
        end else if (cnt == BIT_LAST) begin
          tx_err_n  = 1'b1;
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b0;
          state_n   = IDLE;
        end
      end
      TX_ACK: begin
        if (fall) begin
          cnt_n = '0;
          if (din) tx_err_n  = 1'b1;
          else     tx_done_n = 1'b1;
          state_n = TX_WAIT_IDLE;
        end else if (cnt == BIT_LAST) begin
          tx_err_n  = 1'b1;
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b0;
          state_n   = IDLE;
        end
      end
      TX_WAIT_IDLE: begin
        // Expiry here is silent: the ACK result has already been reported.
        if (lines_high || (cnt == BIT_LAST)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Control registers: synchronisers, state, counters, pad enables, pulses, FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_p0    <= 1'b1;
      clk_p1    <= 1'b1;
      clk_p2    <= 1'b1;
      dat_p0    <= 1'b1;
      dat_p1    <= 1'b1;
      dat_p2    <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      clk_oe    <= 1'b0;
      data_oe   <= 1'b0;
      tx_done_r <= 1'b0;
      tx_err_r  <= 1'b0;
      rx_err_r  <= 1'b0;
      rx_ovf_r  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      clk_p0    <= bus.ps2_clk_i;
      clk_p1    <= clk_p0;
      clk_p2    <= clk_p1;
      dat_p0    <= bus.ps2_data_i;
      dat_p1    <= dat_p0;
      dat_p2    <= dat_p1;
      state     <= state_n;
      cnt       <= cnt_n;
      bit_cnt   <= bit_n;
      clk_oe    <= clk_oe_n;
      data_oe   <= data_oe_n;
      tx_done_r <= tx_done_n;
      tx_err_r  <= tx_err_n;
      rx_err_r  <= rx_err_n;
      rx_ovf_r  <= rx_ovf_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Datapath registers: shift/frame holders and FIFO storage carry no reset.
  always_ff @(posedge clk) begin
    shreg <= shreg_n;
    frame <= frame_n;
    if (push) mem[wr_ptr[AW-1:0]] <= shreg[7:0];
  end

  assign bus.ps2_clk_oe  = clk_oe;
  assign bus.ps2_data_oe = data_oe;
  assign bus.tx_ready    = (state == IDLE) & ~rst;
  assign bus.tx_done     = tx_done_r;
  assign bus.tx_err      = tx_err_r;
  assign bus.rx_data     = mem[rd_ptr[AW-1:0]];
  assign bus.rx_valid    = ~empty;
  assign bus.rx_err      = rx_err_r;
  assign bus.rx_overflow = rx_ovf_r;
  assign bus.busy        = (state != IDLE);

endmodule
